// File: rtl/hamming_best_match.sv
// hamming_best_match
// Scans a run of Hamming distances for one query descriptor and reports the
// best candidate index, best and second-best distance, and a match decision.
// Optional feature: define RATIO_TEST_EN to add a 0.75 best/second ratio test
// to the match decision. Without it, a match only needs best < THRESH.
module hamming_best_match #(
    parameter int DIST_W = 16,
    parameter int IDX_W  = 10,
    parameter int THRESH = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [IDX_W-1:0]  i_cand_num,
    input  logic              i_ready,
    input  logic [DIST_W-1:0] i_value,
    output logic              o_busy,
    output logic              o_ready,
    output logic [IDX_W-1:0]  o_match_idx,
    output logic [DIST_W-1:0] o_best_dist,
    output logic [DIST_W-1:0] o_second_dist,
    output logic              o_match_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [DIST_W-1:0] THRESH_V = DIST_W'(THRESH);

    state_t            state_q, state_d;
    logic [DIST_W-1:0] best_q, best_d;
    logic [DIST_W-1:0] second_q, second_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  num_q, num_d;

    logic              ready_q;
    logic [IDX_W-1:0]  match_idx_q;
    logic [DIST_W-1:0] best_dist_q;
    logic [DIST_W-1:0] second_dist_q;
    logic              match_ok_q;
    logic              match_ok_d;

    // Next-state and running best/second tracking for the scan FSM.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d  = state_q;
        best_d   = best_q;
        second_d = second_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        num_d    = num_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    best_d   = '1;
                    second_d = '1;
                    idx_d    = '0;
                    cnt_d    = '0;
                    num_d    = i_cand_num;
                    // An empty query goes straight to DONE with the reset result.
                    state_d  = (i_cand_num == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (i_ready) begin
                    // Strict compares: ties keep the earliest best and fill second.
                    if (i_value < best_q) begin
                        second_d = best_q;
                        best_d   = i_value;
                        idx_d    = cnt_q;
                    end else if (i_value < second_q) begin
                        second_d = i_value;
                    end
                    cnt_d = cnt_q + IDX_ONE;
                    if (cnt_q == num_q - IDX_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Match decision from the result that is about to be published.
`ifdef RATIO_TEST_EN
    localparam int PROD_W = DIST_W + 2;
    logic [PROD_W-1:0] best_x4;
    logic [PROD_W-1:0] second_x3;

    // Products are widened by two bits so neither can overflow.
    always_comb begin
        best_x4    = {best_d, 2'b00};
        second_x3  = {2'b00, second_d} + {1'b0, second_d, 1'b0};
        match_ok_d = (best_d < THRESH_V) && (best_x4 < second_x3);
    end
`else
    // Absolute threshold only; second-best is still reported.
    always_comb begin
        match_ok_d = (best_d < THRESH_V);
    end
`endif

    // State, scan registers and result registers, loaded on entry to DONE.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (i_rst) begin
            state_q       <= IDLE;
            best_q        <= '0;
            second_q      <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            num_q         <= '0;
            ready_q       <= 1'b0;
            match_idx_q   <= '0;
            best_dist_q   <= '0;
            second_dist_q <= '0;
            match_ok_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            best_q   <= best_d;
            second_q <= second_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            ready_q  <= (state_d == DONE);
            if (state_d == DONE) begin
                match_idx_q   <= idx_d;
                best_dist_q   <= best_d;
                second_dist_q <= second_d;
                match_ok_q    <= match_ok_d;
            end
        end
    end

    assign o_busy        = (state_q != IDLE);
    assign o_ready       = ready_q;
    assign o_match_idx   = match_idx_q;
    assign o_best_dist   = best_dist_q;
    assign o_second_dist = second_dist_q;
    assign o_match_ok    = match_ok_q;

endmodule
